// File: rtl/if_share_arbiter_pkg.sv
// Shared types and helpers for the interface-sharing round-robin arbiter.
package arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_GAP} arb_state_t;

  localparam int unsigned ARB_MAX_REQ = 8;

  function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/if_share_arbiter_if.sv
// Request/grant bundle between the interface requesters and the share arbiter.
interface if_share_arbiter_if #(
  parameter int unsigned N_REQ = 2
);
  localparam int unsigned OW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic [OW-1:0]    owner;
  logic             busy;
  logic             revoke;

  modport master (
    output req, done,
    input  gnt, owner, busy, revoke
  );

  modport slave (
    input  req, done,
    output gnt, owner, busy, revoke
  );
endinterface

// File: rtl/if_share_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate by rr_ptr, take lowest set bit, rotate back.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);
  localparam int unsigned W = $clog2(N);

  logic [2*N-2:0] dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   first_oh;
  logic [W:0]     sum;

  always_comb begin
    dbl      = {req[N-2:0], req};
    rot      = dbl[rr_ptr +: N];
    first_oh = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) begin
        first_oh      = '0;
        first_oh[i-1] = 1'b1;
      end
    end
    sum   = {1'b0, W'(onehot_to_idx(ARB_MAX_REQ'(first_oh)))} + {1'b0, rr_ptr};
    idx   = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    valid = |req;
  end
endmodule

// File: rtl/if_share_arbiter.sv
// Round-robin owner arbiter for the shared one/two resource.
// Optional forced revoke after MAX_HOLD cycles: define ARB_TIMEOUT_EN.
module if_share_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned GAP      = 1
) (
  input logic              clk,
  input logic              rst,
  if_share_arbiter_if.slave bus
);
  localparam int unsigned W          = $clog2(N_REQ);
  localparam logic [W-1:0] LAST_IDX  = W'(N_REQ - 1);
  localparam int unsigned GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [1:0]  GAP_LAST   = GAP_LAST_I[1:0];

  if (N_REQ < 2 || N_REQ > ARB_MAX_REQ || GAP > 3 || MAX_HOLD < 2) begin : g_bad_cfg
    $error("if_share_arbiter: unsupported parameter set");
  end

  arb_state_t       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] gnt_pick;
  logic [W-1:0]     owner_q;
  logic [W-1:0]     rr_ptr_q;
  logic [W-1:0]     ptr_next;
  logic [W-1:0]     pick_idx;
  logic [1:0]       gap_cnt_q;
  logic             busy_q;
  logic             pick_valid;
  logic             owner_done;
  logic             timeout;
  logic             release_now;
  logic             load_grant;

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned   HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                                             hold_cnt_q <= '0;
    else if (load_grant)                                 hold_cnt_q <= '0;
    else if (state_q == ARB_GRANT && hold_cnt_q != HOLD_SAT) hold_cnt_q <= hold_cnt_q + 1'b1;
  end

  // A same-cycle done wins over the timeout, so revoke only fires without it.
  assign timeout    = (hold_cnt_q == HOLD_LAST);
  assign bus.revoke = !rst && (state_q == ARB_GRANT) && timeout && !owner_done;
`else
  assign timeout    = 1'b0;
  assign bus.revoke = 1'b0;
`endif

  always_comb begin
    owner_done  = bus.done[owner_q];
    release_now = (state_q == ARB_GRANT) && (owner_done || !bus.req[owner_q] || timeout);
    ptr_next    = (owner_q == LAST_IDX) ? '0 : owner_q + W'(1);
    gnt_pick    = N_REQ'(1) << pick_idx;
    // Last GAP cycle arbitrates directly, so a release leaves exactly GAP idle cycles.
    load_grant  = pick_valid &&
                  ((state_q == ARB_IDLE) || (state_q == ARB_GAP && gap_cnt_q == GAP_LAST));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      rr_ptr_q  <= '0;
      gap_cnt_q <= '0;
    end else if (load_grant) begin
      state_q <= ARB_GRANT;
      gnt_q   <= gnt_pick;
      owner_q <= pick_idx;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ARB_GRANT: begin
          if (release_now) begin
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            rr_ptr_q  <= ptr_next;
            gap_cnt_q <= '0;
            state_q   <= (GAP > 0) ? ARB_GAP : ARB_IDLE;
          end
        end
        ARB_GAP: begin
          if (gap_cnt_q == GAP_LAST) state_q   <= ARB_IDLE;
          else                       gap_cnt_q <= gap_cnt_q + 2'd1;
        end
        ARB_IDLE: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_if_share_arbiter.sv
// Directed self-checking bench for if_share_arbiter (N_REQ=2, MAX_HOLD=16, GAP=1).
module tb_if_share_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   failed;

  if_share_arbiter_if #(.N_REQ(2)) bus ();

  if_share_arbiter #(.N_REQ(2), .MAX_HOLD(16), .GAP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant must never be more than one-hot, and busy must track it.
  always @(negedge clk) begin
    tests++;
    assert ($onehot0(bus.gnt) && (bus.busy === (|bus.gnt)))
    else begin
      failed++;
      $error("FAIL onehot0: observed gnt=%0b busy=%0b expected onehot0 and busy=|gnt",
             bus.gnt, bus.busy);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed time limit expired expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests    = 0;
    failed   = 0;
    rst      = 1'b1;
    bus.req  = 2'b11;
    bus.done = 2'b00;

    // Reset held with both requesting
    repeat (3) begin
      tick;
      chk("rst_gnt",    32'(bus.gnt),    32'h0);
      chk("rst_busy",   32'(bus.busy),   32'h0);
      chk("rst_owner",  32'(bus.owner),  32'h0);
      chk("rst_revoke", 32'(bus.revoke), 32'h0);
    end
    rst = 1'b0;
    tick;
    chk("first_gnt",   32'(bus.gnt),   32'h1);
    chk("first_busy",  32'(bus.busy),  32'h1);
    chk("first_owner", 32'(bus.owner), 32'h0);

    // Non-owner done is ignored; owner 0 releases in its 4th grant cycle
    bus.done = 2'b10;
    tick; chk("ign_done_c2", 32'(bus.gnt), 32'h1);
    bus.done = 2'b00;
    tick; chk("alt_a_c3", 32'(bus.gnt), 32'h1);
    tick; chk("alt_a_c4", 32'(bus.gnt), 32'h1);
    bus.done = 2'b01;
    tick;
    chk("alt_gap1",       32'(bus.gnt),   32'h0);
    chk("alt_gap1_busy",  32'(bus.busy),  32'h0);
    chk("alt_gap1_owner", 32'(bus.owner), 32'h0);
    bus.done = 2'b00;
    tick;
    chk("alt_b_gnt",   32'(bus.gnt),   32'h2);
    chk("alt_b_owner", 32'(bus.owner), 32'h1);
    tick; chk("alt_b_c2", 32'(bus.gnt), 32'h2);
    tick; chk("alt_b_c3", 32'(bus.gnt), 32'h2);
    tick; chk("alt_b_c4", 32'(bus.gnt), 32'h2);
    bus.done = 2'b10;
    tick; chk("alt_gap2", 32'(bus.gnt), 32'h0);
    bus.done = 2'b00;
    tick;
    chk("alt_c_gnt",   32'(bus.gnt),   32'h1);
    chk("alt_c_owner", 32'(bus.owner), 32'h0);

    // Owner drops req; requester 1 alone, done with req held regrants after one gap
    bus.req = 2'b10;
    tick; chk("drop_gap",   32'(bus.gnt), 32'h0);
    tick; chk("only1_gnt",  32'(bus.gnt), 32'h2);
    bus.done = 2'b10;
    tick;
    chk("regrant_gap",       32'(bus.gnt),   32'h0);
    chk("regrant_gap_owner", 32'(bus.owner), 32'h1);
    bus.done = 2'b00;
    tick;
    chk("regrant_gnt",   32'(bus.gnt),   32'h2);
    chk("regrant_owner", 32'(bus.owner), 32'h1);

    // Reset mid-grant
    rst = 1'b1;
    tick;
    chk("midrst_gnt",    32'(bus.gnt),    32'h0);
    chk("midrst_owner",  32'(bus.owner),  32'h0);
    chk("midrst_busy",   32'(bus.busy),   32'h0);
    chk("midrst_revoke", 32'(bus.revoke), 32'h0);
    rst     = 1'b0;
    bus.req = 2'b00;
    tick;
    chk("idle_noreq_gnt", 32'(bus.gnt), 32'h0);

    // Long hold with no done
    bus.req = 2'b01;
    tick;
    for (int k = 1; k <= 15; k++) begin
      chk("hold_gnt",    32'(bus.gnt),    32'h1);
      chk("hold_revoke", 32'(bus.revoke), 32'h0);
      tick;
    end
`ifdef ARB_TIMEOUT_EN
    chk("to_revoke_c16", 32'(bus.revoke), 32'h1);
    chk("to_gnt_c16",    32'(bus.gnt),    32'h1);
    tick;
    chk("to_gnt_drop",   32'(bus.gnt),    32'h0);
    chk("to_revoke_off", 32'(bus.revoke), 32'h0);
    tick;
    chk("to_regrant", 32'(bus.gnt), 32'h1);
`else
    for (int k = 16; k <= 100; k++) begin
      chk("persist_gnt",    32'(bus.gnt),    32'h1);
      chk("persist_revoke", 32'(bus.revoke), 32'h0);
      tick;
    end
    chk("persist_busy", 32'(bus.busy), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
